// File: rtl/dw_conv_sched.sv
// Channel scheduler for the 3x3 line buffer: replays one layer command once per channel,
// gating exactly H*W pixels into the buffer and counting OH*OW windows out of it.
module dw_conv_sched #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIM_W  = 8,
  parameter int unsigned CH_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DIM_W-1:0]  cmd_img_h,
  input  logic [DIM_W-1:0]  cmd_img_w,
  input  logic [3:0]        cmd_stride,
  input  logic [CH_W-1:0]   cmd_channels,
  input  logic              px_valid,
  output logic              px_ready,
  input  logic [DATA_W-1:0] px_data,
  output logic              lb_start,
  output logic [DIM_W-1:0]  lb_cfg_img_h,
  output logic [DIM_W-1:0]  lb_cfg_img_w,
  output logic [3:0]        lb_cfg_stride,
  output logic              lb_in_valid,
  input  logic              lb_in_ready,
  output logic [DATA_W-1:0] lb_in_data,
  input  logic              lb_out_valid,
  output logic              lb_out_ready,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [CH_W-1:0]   ch_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CntW = 2 * DIM_W;

  typedef enum logic [2:0] {StIdle, StStart, StStream, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [DIM_W-1:0] img_h_q, img_w_q;
  logic [3:0]       stride_q;
  logic [CH_W-1:0]  chans_q, ch_idx_q, ch_idx_d;
  logic [CntW-1:0]  pix_total_q, win_total_q;
  logic [CntW-1:0]  pix_cnt_q, pix_cnt_d, win_cnt_q, win_cnt_d;
  logic             err_q, err_d;

  logic             cmd_fire, cmd_illegal, gate_open, counting;
  logic             px_fire, win_fire, pix_last, plane_done, last_ch;
  logic [DIM_W:0]   oh_c, ow_c;
  logic [CntW-1:0]  pix_total_c, win_total_c;

  // Output dims via shifts: stride is restricted to 1 or 2.
  always_comb begin
    cmd_illegal = (cmd_img_h == '0) || (cmd_img_w == '0) || (cmd_channels == '0) ||
                  !((cmd_stride == 4'd1) || (cmd_stride == 4'd2));
    oh_c = (cmd_stride == 4'd2) ? (({1'b0, cmd_img_h} + (DIM_W + 1)'(1)) >> 1)
                                : {1'b0, cmd_img_h};
    ow_c = (cmd_stride == 4'd2) ? (({1'b0, cmd_img_w} + (DIM_W + 1)'(1)) >> 1)
                                : {1'b0, cmd_img_w};
    pix_total_c = CntW'(cmd_img_h) * CntW'(cmd_img_w);
    win_total_c = CntW'(oh_c) * CntW'(ow_c);
  end

  // FSM outputs; reset forces everything idle in the cycle it is sampled.
  always_comb begin
    cmd_ready = 1'b0;
    lb_start  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    gate_open = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StIdle:   cmd_ready = 1'b1;
        StStart:  begin lb_start = 1'b1; busy = 1'b1; end
        StStream: begin busy = 1'b1; gate_open = 1'b1; end
        StDrain:  busy = 1'b1;
        StDone:   begin busy = 1'b1; done = 1'b1; end
        default:  ;
      endcase
    end
  end

  always_comb begin
    px_ready     = gate_open & lb_in_ready;
    lb_in_valid  = gate_open & px_valid;
    lb_in_data   = px_data;
    win_valid    = lb_out_valid;
    lb_out_ready = win_ready;
    px_fire      = px_valid & px_ready;
    win_fire     = lb_out_valid & win_ready;
    counting     = (state_q == StStream) || (state_q == StDrain);
    cmd_fire     = cmd_ready & cmd_valid;
  end

  always_comb begin
    pix_cnt_d = pix_cnt_q;
    win_cnt_d = win_cnt_q;
    if (state_q == StStart) begin
      pix_cnt_d = '0;
      win_cnt_d = '0;
    end else begin
      if (px_fire)              pix_cnt_d = pix_cnt_q + CntW'(1);
      if (counting && win_fire) win_cnt_d = win_cnt_q + CntW'(1);
    end
    pix_last   = px_fire && (pix_cnt_d == pix_total_q);
    plane_done = (state_q == StDrain) && (win_cnt_d >= win_total_q);
    last_ch    = (ch_idx_q == chans_q - CH_W'(1));
    // Windows outside a channel pass through uncounted but are flagged.
    err_d      = (cmd_fire & cmd_illegal) | (win_fire & ~counting);
    ch_idx_d   = ch_idx_q;
    if (cmd_fire)                    ch_idx_d = '0;
    else if (plane_done && !last_ch) ch_idx_d = ch_idx_q + CH_W'(1);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cmd_valid && !cmd_illegal) state_d = StStart;
      StStart:  state_d = StStream;
      StStream: if (pix_last) state_d = StDrain;
      StDrain:  if (plane_done) state_d = last_ch ? StDone : StStart;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      img_h_q     <= '0;
      img_w_q     <= '0;
      stride_q    <= '0;
      chans_q     <= '0;
      pix_total_q <= '0;
      win_total_q <= '0;
      ch_idx_q    <= '0;
      pix_cnt_q   <= '0;
      win_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      if (cmd_fire) begin
        img_h_q     <= cmd_img_h;
        img_w_q     <= cmd_img_w;
        stride_q    <= cmd_stride;
        chans_q     <= cmd_channels;
        pix_total_q <= pix_total_c;
        win_total_q <= win_total_c;
      end
      ch_idx_q  <= ch_idx_d;
      pix_cnt_q <= pix_cnt_d;
      win_cnt_q <= win_cnt_d;
      err_q     <= err_d;
    end
  end

  assign lb_cfg_img_h  = img_h_q;
  assign lb_cfg_img_w  = img_w_q;
  assign lb_cfg_stride = stride_q;
  assign ch_idx        = ch_idx_q;
  assign err           = err_q;

endmodule

// File: tb/tb_dw_conv_sched.sv
// Bench for dw_conv_sched: a behavioural line buffer releases windows in proportion to the
// pixels it has received; pixel data and channel/done timing are tracked through queues.
module tb_dw_conv_sched;

  localparam int DATA_W = 8;
  localparam int DIM_W  = 8;
  localparam int CH_W   = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready;
  logic [DIM_W-1:0]  cmd_img_h, cmd_img_w;
  logic [3:0]        cmd_stride;
  logic [CH_W-1:0]   cmd_channels;
  logic              px_valid, px_ready;
  logic [DATA_W-1:0] px_data;
  logic              lb_start;
  logic [DIM_W-1:0]  lb_cfg_img_h, lb_cfg_img_w;
  logic [3:0]        lb_cfg_stride;
  logic              lb_in_valid, lb_in_ready;
  logic [DATA_W-1:0] lb_in_data;
  logic              lb_out_valid, lb_out_ready;
  logic              win_valid, win_ready;
  logic [CH_W-1:0]   ch_idx;
  logic              busy, done, err;

  dw_conv_sched #(.DATA_W(DATA_W), .DIM_W(DIM_W), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_img_h(cmd_img_h), .cmd_img_w(cmd_img_w),
    .cmd_stride(cmd_stride), .cmd_channels(cmd_channels),
    .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data),
    .lb_start(lb_start),
    .lb_cfg_img_h(lb_cfg_img_h), .lb_cfg_img_w(lb_cfg_img_w), .lb_cfg_stride(lb_cfg_stride),
    .lb_in_valid(lb_in_valid), .lb_in_ready(lb_in_ready), .lb_in_data(lb_in_data),
    .lb_out_valid(lb_out_valid), .lb_out_ready(lb_out_ready),
    .win_valid(win_valid), .win_ready(win_ready),
    .ch_idx(ch_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h, w, s, c, rm, wm;
    int e_starts, e_pix, e_win, e_done, e_err;
  } vec_t;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int rmode = 0, wmode = 0;
  bit force_win = 1'b0, after_start = 1'b0;
  int hw_m = 0, ohow_m = 0, c_m = 0, chpix = 0, lb_win = 0;
  int starts, pixels, wins, dones, errs, busy_cyc;
  logic [DATA_W-1:0] sb_q[$];
  int exp_start_q[$];
  int exp_done_q[$];
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_counts();
    starts = 0; pixels = 0; wins = 0; dones = 0; errs = 0; busy_cyc = 0;
    chpix = 0; lb_win = 0;
    sb_q.delete(); exp_start_q.delete(); exp_done_q.delete();
  endtask

  // One clock: drive at the falling edge, sample 1 time unit later.
  task automatic tick(input bit cv, input bit r);
    @(negedge clk);
    rst          = r;
    cmd_valid    = cv;
    px_valid     = 1'b1;
    px_data      = DATA_W'($urandom);
    lb_in_ready  = (rmode == 1) ? (cyc % 4 == 0) : 1'b1;
    win_ready    = (wmode == 1) ? (cyc % 2 == 0) : 1'b1;
    lb_out_valid = force_win || (hw_m > 0 && lb_win < chpix * ohow_m / hw_m);
    #1;
    cyc++;
    chk("win_valid passthrough", win_valid, lb_out_valid);
    chk("lb_out_ready passthrough", lb_out_ready, win_ready);
    if (lb_start) begin
      starts++;
      chk("px_ready in START", px_ready, 0);
      if (exp_start_q.size() > 0) chk("lb_start cycle", cyc, exp_start_q.pop_front());
      else chk("unexpected lb_start", 1, 0);
      chpix = 0; lb_win = 0; after_start = 1'b1;
    end else if (after_start) begin
      chk("px_ready first STREAM", px_ready, lb_in_ready);
      after_start = 1'b0;
    end
    if (busy) begin
      busy_cyc++;
      chk("ch_idx", ch_idx, starts - 1);
    end
    if (hw_m > 0 && chpix >= hw_m) chk("px_ready after plane", px_ready, 0);
    if (px_valid && px_ready) begin
      sb_q.push_back(px_data);
      pixels++;
    end
    if (lb_in_valid && lb_in_ready) begin
      if (sb_q.size() == 0) chk("lb_in without upstream pixel", 1, 0);
      else chk("lb_in_data", lb_in_data, sb_q.pop_front());
      chpix++;
    end
    if (lb_out_valid && win_ready && !force_win) begin
      wins++;
      lb_win++;
      if (lb_win == ohow_m) begin
        if (starts == c_m) exp_done_q.push_back(cyc + 1);
        else exp_start_q.push_back(cyc + 1);
      end
    end
    if (done) begin
      dones++;
      if (exp_done_q.size() > 0) chk("done cycle", cyc, exp_done_q.pop_front());
      else chk("unexpected done", 1, 0);
    end
    if (err) errs++;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bit legal;
    int oh, ow;
    legal = (v.e_starts > 0);
    rmode = v.rm; wmode = v.wm;
    cmd_img_h = DIM_W'(v.h); cmd_img_w = DIM_W'(v.w);
    cmd_stride = 4'(v.s); cmd_channels = CH_W'(v.c);
    oh = (v.s == 2) ? (v.h + 1) / 2 : v.h;
    ow = (v.s == 2) ? (v.w + 1) / 2 : v.w;
    hw_m = v.h * v.w; ohow_m = oh * ow; c_m = v.c;
    clear_counts();
    tick(1'b1, 1'b0);
    chk({tag, " cmd_ready"}, cmd_ready, 1);
    if (legal) exp_start_q.push_back(cyc + 1);
    tick(1'b0, 1'b0);
    chk({tag, " cfg_h"}, lb_cfg_img_h, v.h);
    chk({tag, " cfg_w"}, lb_cfg_img_w, v.w);
    chk({tag, " cfg_s"}, lb_cfg_stride, v.s);
    chk({tag, " busy after accept"}, busy, legal);
    chk({tag, " err after accept"}, err, !legal);
    for (int i = 0; i < 4000; i++) begin
      if (legal ? (dones > 0) : (i >= 5)) break;
      tick(1'b0, 1'b0);
    end
    if (legal) begin
      if (dones == 0) chk({tag, " done timeout"}, 0, 1);
      tick(1'b0, 1'b0);
      chk({tag, " busy after done"}, busy, 0);
      chk({tag, " cmd_ready after done"}, cmd_ready, 1);
    end else begin
      chk({tag, " busy cycles"}, busy_cyc, 0);
    end
    chk({tag, " lb_start pulses"}, starts, v.e_starts);
    chk({tag, " pixels"}, pixels, v.e_pix);
    chk({tag, " windows"}, wins, v.e_win);
    chk({tag, " done pulses"}, dones, v.e_done);
    chk({tag, " err pulses"}, errs, v.e_err);
    chk({tag, " pixel queue empty"}, sb_q.size(), 0);
    chk({tag, " pending events"}, exp_start_q.size() + exp_done_q.size(), 0);
  endtask

  initial begin
    //           h   w  s  c rm wm starts pix win done err
    vecs[0] = '{ 5,  5, 2, 1, 0, 0, 1,  25,   9, 1, 0};
    vecs[1] = '{ 4,  4, 1, 3, 0, 0, 3,  48,  48, 1, 0};
    vecs[2] = '{ 5,  5, 2, 1, 1, 1, 1,  25,   9, 1, 0};
    vecs[3] = '{ 5,  5, 3, 1, 0, 0, 0,   0,   0, 0, 1};
    vecs[4] = '{ 0,  5, 1, 1, 0, 0, 0,   0,   0, 0, 1};
    vecs[5] = '{ 5,  5, 1, 0, 0, 0, 0,   0,   0, 0, 1};
    vecs[6] = '{ 3,  7, 2, 2, 1, 0, 2,  42,  16, 1, 0};
    vecs[7] = '{ 1,  1, 2, 1, 0, 1, 1,   1,   1, 1, 0};
    vecs[8] = '{17, 16, 1, 1, 0, 0, 1, 272, 272, 1, 0};
    vecs[9] = '{ 5,  5, 2, 1, 0, 0, 1,  25,   9, 1, 0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_img_h = '0; cmd_img_w = '0;
    cmd_stride = '0; cmd_channels = '0; px_valid = 1'b0; px_data = '0;
    lb_in_ready = 1'b1; lb_out_valid = 1'b0; win_ready = 1'b1;
    clear_counts();

    tick(1'b0, 1'b1);
    chk("cmd_ready in reset", cmd_ready, 0);
    tick(1'b0, 1'b0);
    chk("reset cmd_ready", cmd_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset lb_start", lb_start, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk("reset ch_idx", ch_idx, 0);
    chk("reset cfg", {lb_cfg_img_h, lb_cfg_img_w, lb_cfg_stride}, 0);
    chk("reset gate", {px_ready, lb_in_valid}, 0);

    for (int k = 0; k < 9; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Stray window while idle: passed through, flagged one cycle later.
    force_win = 1'b1; rmode = 0; wmode = 0;
    tick(1'b0, 1'b0);
    chk("stray win_valid", win_valid, 1);
    chk("stray err same cycle", err, 0);
    force_win = 1'b0;
    tick(1'b0, 1'b0);
    chk("stray err pulse", err, 1);
    tick(1'b0, 1'b0);
    chk("stray err cleared", err, 0);

    // Reset after 12 pixels of channel 0 in a two-channel layer.
    cmd_img_h = 8'd5; cmd_img_w = 8'd5; cmd_stride = 4'd2; cmd_channels = 10'd2;
    hw_m = 25; ohow_m = 9; c_m = 2;
    clear_counts();
    tick(1'b1, 1'b0);
    exp_start_q.push_back(cyc + 1);
    for (int i = 0; i < 200 && pixels < 12; i++) tick(1'b0, 1'b0);
    chk("pixels before reset", pixels, 12);
    tick(1'b0, 1'b1);
    chk("gate px_ready in reset", px_ready, 0);
    chk("gate lb_in_valid in reset", lb_in_valid, 0);
    chk("cmd_ready in mid reset", cmd_ready, 0);
    chpix = 0; lb_win = 0;
    exp_start_q.delete(); exp_done_q.delete();
    tick(1'b0, 1'b0);
    chk("post-reset busy", busy, 0);
    chk("post-reset cmd_ready", cmd_ready, 1);
    chk("post-reset ch_idx", ch_idx, 0);
    chk("post-reset done pulses", dones, 0);
    run_vec(vecs[9], "after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
